// File: rtl/dmem_access_seq.sv
// Load/store access sequencer: aligned accesses pass straight through, misaligned H/W accesses are split into byte
// accesses. The split path is built only when DMEM_MISALIGN_SPLIT_EN is defined; otherwise misaligned requests fault.
module dmem_access_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_fun3,
    output logic             req_ready,
    output logic             stall,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [2:0]       mem_fun3,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam logic [1:0] ST_SPLIT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
`endif

    // Byte loads/stores and reserved encodings are never treated as misaligned.
    function automatic logic f_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
        logic res;
        case (fun3)
            3'b001, 3'b101: res = addr_lo[0];
            3'b010:         res = (addr_lo != 2'b00);
            default:        res = 1'b0;
        endcase
        return res;
    endfunction

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_misaligned;

    assign w_misaligned = f_misaligned(req_fun3, req_addr[1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [2:0]       r_fun3;
    logic             r_write;
    logic [1:0]       r_cnt;
    logic [1:0]       r_last;
    logic [WIDTH-1:0] r_asm;
    logic [7:0]       w_wbyte;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && w_misaligned) begin
                    w_state_nxt = ST_SPLIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SPLIT: begin
                if (r_cnt == r_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SPLIT;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, byte counter and load-assembly register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= {WIDTH{1'b0}};
            r_wdata <= {WIDTH{1'b0}};
            r_fun3  <= 3'b000;
            r_write <= 1'b0;
            r_cnt   <= 2'd0;
            r_last  <= 2'd0;
            r_asm   <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && w_misaligned) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_fun3  <= req_fun3;
                        r_write <= req_write;
                        r_cnt   <= 2'd0;
                        r_last  <= (req_fun3 == 3'b010) ? 2'd3 : 2'd1;
                    end
                end
                ST_SPLIT: begin
                    if (!r_write) begin
                        case (r_cnt)
                            2'd0:    r_asm[7:0]   <= mem_rdata[7:0];
                            2'd1:    r_asm[15:8]  <= mem_rdata[7:0];
                            2'd2:    r_asm[23:16] <= mem_rdata[7:0];
                            default: r_asm[31:24] <= mem_rdata[7:0];
                        endcase
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (r_cnt)
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = {WIDTH{1'b0}};
        rsp_err   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_fun3  = req_fun3;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_misaligned) begin
                    stall = req_valid;
                end else begin
                    mem_write = req_valid & req_write;
                    rsp_valid = req_valid;
                    rsp_rdata = req_write ? {WIDTH{1'b0}} : mem_rdata;
                end
            end
            ST_SPLIT: begin
                stall     = 1'b1;
                mem_addr  = r_addr + {{(WIDTH-2){1'b0}}, r_cnt};
                mem_fun3  = r_write ? 3'b000 : 3'b100;
                mem_write = r_write;
                mem_wdata = {{(WIDTH-8){1'b0}}, w_wbyte};
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (r_write) begin
                    rsp_rdata = {WIDTH{1'b0}};
                end else begin
                    case (r_fun3)
                        3'b001:  rsp_rdata = {{(WIDTH-16){r_asm[15]}}, r_asm[15:0]};
                        3'b101:  rsp_rdata = {{(WIDTH-16){1'b0}}, r_asm[15:0]};
                        default: rsp_rdata = r_asm;
                    endcase
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

`else
    always_comb begin
        case (r_state)
            ST_IDLE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Misaligned requests are answered at once with a fault and never touch memory.
    always_comb begin
        req_ready = 1'b0;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = {WIDTH{1'b0}};
        rsp_err   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_fun3  = req_fun3;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_misaligned) begin
                    rsp_valid = req_valid;
                    rsp_err   = req_valid;
                end else begin
                    mem_write = req_valid & req_write;
                    rsp_valid = req_valid;
                    rsp_rdata = req_write ? {WIDTH{1'b0}} : mem_rdata;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq with a byte-array memory model; split tests build when DMEM_MISALIGN_SPLIT_EN is set.
module tb_dmem_access_seq;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_fun3;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_fun3;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_bad;

    logic [7:0]  mem [0:4095];
    logic [11:0] a0;
    logic [11:0] a1;
    logic [11:0] a2;
    logic [11:0] a3;

    dmem_access_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_fun3(req_fun3), .req_ready(req_ready),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_fun3(mem_fun3), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a0 = mem_addr[11:0];
    assign a1 = mem_addr[11:0] + 12'd1;
    assign a2 = mem_addr[11:0] + 12'd2;
    assign a3 = mem_addr[11:0] + 12'd3;

    // Memory model: combinational read with extension, byte-enabled write on the clock edge.
    always_comb begin
        case (mem_fun3)
            3'b000:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
            3'b100:  mem_rdata = {24'h000000, mem[a0]};
            3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b101:  mem_rdata = {16'h0000, mem[a1], mem[a0]};
            default: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_fun3)
                3'b000: mem[a0] <= mem_wdata[7:0];
                3'b001: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                end
                3'b010: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                    mem[a2] <= mem_wdata[23:16];
                    mem[a3] <= mem_wdata[31:24];
                end
                default: begin
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_fun3  = f;
        #1;
    endtask

    task automatic test_reset();
        if (rsp_valid !== 1'b0) begin $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
        if (rsp_err !== 1'b0) begin $display("FAIL reset_rsp_err: got %b want 0", rsp_err); n_bad++; end n_cmp++;
        if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); n_bad++; end n_cmp++;
        if (mem_write !== 1'b0) begin $display("FAIL reset_mem_write: got %b want 0", mem_write); n_bad++; end n_cmp++;
        if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %b want 1", req_ready); n_bad++; end n_cmp++;
    endtask

    task automatic test_aligned();
        drive(1'b1, 1'b1, 32'h100, 32'h12345678, 3'b010);
        if (rsp_valid !== 1'b1) begin $display("FAIL sw_rsp_valid: got %b want 1", rsp_valid); n_bad++; end n_cmp++;
        if (mem_write !== 1'b1) begin $display("FAIL sw_mem_write: got %b want 1", mem_write); n_bad++; end n_cmp++;
        if (stall !== 1'b0) begin $display("FAIL sw_stall: got %b want 0", stall); n_bad++; end n_cmp++;
        if (rsp_rdata !== 32'h0) begin $display("FAIL sw_rdata: got %h want 00000000", rsp_rdata); n_bad++; end n_cmp++;
        if (mem_addr !== 32'h100) begin $display("FAIL sw_addr: got %h want 00000100", mem_addr); n_bad++; end n_cmp++;
        if (mem_wdata !== 32'h12345678) begin $display("FAIL sw_wdata: got %h want 12345678", mem_wdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        if (rsp_valid !== 1'b1) begin $display("FAIL lw_rsp_valid: got %b want 1", rsp_valid); n_bad++; end n_cmp++;
        if (rsp_rdata !== 32'h12345678) begin $display("FAIL lw_rdata: got %h want 12345678", rsp_rdata); n_bad++; end n_cmp++;
        if (stall !== 1'b0) begin $display("FAIL lw_stall: got %b want 0", stall); n_bad++; end n_cmp++;
        if (mem_write !== 1'b0) begin $display("FAIL lw_mem_write: got %b want 0", mem_write); n_bad++; end n_cmp++;
        if (rsp_err !== 1'b0) begin $display("FAIL lw_rsp_err: got %b want 0", rsp_err); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b1, 32'h100, 32'h00008001, 3'b001);
        tick();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b001);
        if (rsp_rdata !== 32'hFFFF8001) begin $display("FAIL lh_al_rdata: got %h want ffff8001", rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b101);
        if (rsp_rdata !== 32'h00008001) begin $display("FAIL lhu_al_rdata: got %h want 00008001", rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b000);
        if (rsp_rdata !== 32'hFFFFFF80) begin $display("FAIL lb_rdata: got %h want ffffff80", rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h103, 32'h0, 3'b100);
        if (rsp_rdata !== 32'h00000012) begin $display("FAIL lbu_rdata: got %h want 00000012", rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        if (rsp_rdata !== 32'h12348001) begin $display("FAIL lw2_rdata: got %h want 12348001", rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b0, 1'b1, 32'h100, 32'h0, 3'b010);
        if (mem_write !== 1'b0) begin $display("FAIL novalid_mem_write: got %b want 0", mem_write); n_bad++; end n_cmp++;
        if (rsp_valid !== 1'b0) begin $display("FAIL novalid_rsp_valid: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
        if (req_ready !== 1'b1) begin $display("FAIL novalid_ready: got %b want 1", req_ready); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b1, 32'h101, 32'h0, 3'b011);
        if (stall !== 1'b0) begin $display("FAIL rsvd_stall: got %b want 0", stall); n_bad++; end n_cmp++;
        if (mem_write !== 1'b1) begin $display("FAIL rsvd_mem_write: got %b want 1", mem_write); n_bad++; end n_cmp++;
        if (mem_fun3 !== 3'b011) begin $display("FAIL rsvd_fun3: got %b want 011", mem_fun3); n_bad++; end n_cmp++;
        if (rsp_valid !== 1'b1) begin $display("FAIL rsvd_rsp_valid: got %b want 1", rsp_valid); n_bad++; end n_cmp++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

`ifdef DMEM_MISALIGN_SPLIT_EN
    task automatic test_split_store();
        logic [31:0] exp_w;
        exp_w = 32'hAABBCCDD;
        drive(1'b1, 1'b1, 32'h101, exp_w, 3'b010);
        if (stall !== 1'b1) begin $display("FAIL ssw_acc_stall: got %b want 1", stall); n_bad++; end n_cmp++;
        if (mem_write !== 1'b0) begin $display("FAIL ssw_acc_mem_write: got %b want 0", mem_write); n_bad++; end n_cmp++;
        if (rsp_valid !== 1'b0) begin $display("FAIL ssw_acc_rsp_valid: got %b want 0", rsp_valid); n_bad++; end n_cmp++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_addr !== 32'h101 + k) begin $display("FAIL ssw_addr%0d: got %h want %h", k, mem_addr, 32'h101 + k); n_bad++; end n_cmp++;
            if (mem_write !== 1'b1 || mem_fun3 !== 3'b000) begin $display("FAIL ssw_sb%0d: got w=%b f=%b want w=1 f=000", k, mem_write, mem_fun3); n_bad++; end n_cmp++;
            if (mem_wdata !== {24'h0, exp_w[8*k +: 8]}) begin $display("FAIL ssw_wdata%0d: got %h want %h", k, mem_wdata, {24'h0, exp_w[8*k +: 8]}); n_bad++; end n_cmp++;
            if (stall !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL ssw_ctl%0d: got st=%b rdy=%b rv=%b want 1 0 0", k, stall, req_ready, rsp_valid); n_bad++; end n_cmp++;
        end
        tick();
        // Next request presented in DONE must be ignored.
        drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b010);
        if (rsp_valid !== 1'b1 || stall !== 1'b0 || req_ready !== 1'b0) begin $display("FAIL ssw_done_ctl: got rv=%b st=%b rdy=%b want 1 0 0", rsp_valid, stall, req_ready); n_bad++; end n_cmp++;
        if (rsp_rdata !== 32'h0 || mem_write !== 1'b0 || rsp_err !== 1'b0) begin $display("FAIL ssw_done_data: got rd=%h w=%b err=%b want 0 0 0", rsp_rdata, mem_write, rsp_err); n_bad++; end n_cmp++;
        if ({mem[12'h104], mem[12'h103], mem[12'h102], mem[12'h101]} !== exp_w) begin $display("FAIL ssw_mem: got %h want aabbccdd", {mem[12'h104], mem[12'h103], mem[12'h102], mem[12'h101]}); n_bad++; end n_cmp++;
        tick();
        if (stall !== 1'b1) begin $display("FAIL slw_acc_stall: got %b want 1", stall); n_bad++; end n_cmp++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_fun3 !== 3'b100 || mem_write !== 1'b0) begin $display("FAIL slw_lbu%0d: got f=%b w=%b want 100 0", k, mem_fun3, mem_write); n_bad++; end n_cmp++;
        end
        tick();
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_w) begin $display("FAIL slw_done: got rv=%b rd=%h want 1 aabbccdd", rsp_valid, rsp_rdata); n_bad++; end n_cmp++;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
    endtask

    task automatic test_split_load_sign();
        drive(1'b1, 1'b1, 32'h103, 32'h7F, 3'b000);
        tick();
        drive(1'b1, 1'b1, 32'h104, 32'h80, 3'b000);
        tick();
        drive(1'b1, 1'b0, 32'h103, 32'h0, 3'b001);
        for (int c = 1; c <= 2; c++) begin
            tick();
            if (rsp_valid !== 1'b0) begin $display("FAIL lh_early_rsp%0d: got %b want 0", c, rsp_valid); n_bad++; end n_cmp++;
        end
        tick();
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF807F) begin $display("FAIL lh_split: got rv=%b rd=%h want 1 ffff807f", rsp_valid, rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h103, 32'h0, 3'b101);
        tick();
        tick();
        tick();
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000807F) begin $display("FAIL lhu_split: got rv=%b rd=%h want 1 0000807f", rsp_valid, rsp_rdata); n_bad++; end n_cmp++;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFFFFFF;
        exp_a[1] = 32'h0;
        exp_a[2] = 32'h1;
        exp_a[3] = 32'h2;
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h11223344, 3'b010);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (mem_addr !== exp_a[k]) begin $display("FAIL wrap_addr%0d: got %h want %h", k, mem_addr, exp_a[k]); n_bad++; end n_cmp++;
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        if ({mem[12'h002], mem[12'h001], mem[12'h000], mem[12'hFFF]} !== 32'h11223344) begin $display("FAIL wrap_mem: got %h want 11223344", {mem[12'h002], mem[12'h001], mem[12'h000], mem[12'hFFF]}); n_bad++; end n_cmp++;
        tick();
    endtask

    task automatic test_reset_mid_split();
        drive(1'b1, 1'b1, 32'h200, 32'h03020100, 3'b010);
        tick();
        drive(1'b1, 1'b1, 32'h204, 32'h07060504, 3'b010);
        tick();
        drive(1'b1, 1'b1, 32'h201, 32'hDEADBEEF, 3'b010);
        tick();
        tick();
        if (mem_addr !== 32'h202) begin $display("FAIL rst_k1_addr: got %h want 00000202", mem_addr); n_bad++; end n_cmp++;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        if (mem_write !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL rst_mid_out: got w=%b rv=%b want 0 0", mem_write, rsp_valid); n_bad++; end n_cmp++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin $display("FAIL rst_mid_idle: got rdy=%b st=%b want 1 0", req_ready, stall); n_bad++; end n_cmp++;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || mem_write !== 1'b0) begin $display("FAIL rst_after%0d: got rv=%b w=%b want 0 0", c, rsp_valid, mem_write); n_bad++; end n_cmp++;
        end
        if ({mem[12'h204], mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} !== 40'h040302EF00) begin
            $display("FAIL rst_mem: got %h want 040302ef00", {mem[12'h204], mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}); n_bad++;
        end
        n_cmp++;
    endtask
`else
    task automatic test_misalign_err();
        drive(1'b1, 1'b0, 32'h102, 32'h0, 3'b010);
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin $display("FAIL err_lw: got rv=%b err=%b want 1 1", rsp_valid, rsp_err); n_bad++; end n_cmp++;
        if (mem_write !== 1'b0 || rsp_rdata !== 32'h0 || stall !== 1'b0) begin $display("FAIL err_lw_out: got w=%b rd=%h st=%b want 0 0 0", mem_write, rsp_rdata, stall); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b1, 32'h101, 32'hDEADBEEF, 3'b010);
        if (mem_write !== 1'b0 || rsp_err !== 1'b1 || rsp_valid !== 1'b1) begin $display("FAIL err_sw: got w=%b err=%b rv=%b want 0 1 1", mem_write, rsp_err, rsp_valid); n_bad++; end n_cmp++;
        tick();
        if (mem[12'h101] !== 8'h80) begin $display("FAIL err_sw_mem: got %h want 80", mem[12'h101]); n_bad++; end n_cmp++;
        drive(1'b1, 1'b0, 32'h101, 32'h0, 3'b001);
        if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin $display("FAIL err_lh: got err=%b rd=%h want 1 0", rsp_err, rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b1, 32'h103, 32'h0, 3'b001);
        if (rsp_err !== 1'b1 || mem_write !== 1'b0) begin $display("FAIL err_sh: got err=%b w=%b want 1 0", rsp_err, mem_write); n_bad++; end n_cmp++;
        tick();
        drive(1'b1, 1'b0, 32'h102, 32'h0, 3'b101);
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h00001234) begin $display("FAIL al_lhu102: got err=%b rd=%h want 0 00001234", rsp_err, rsp_rdata); n_bad++; end n_cmp++;
        tick();
        drive(1'b0, 1'b0, 32'h103, 32'h0, 3'b010);
        if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin $display("FAIL err_novalid: got err=%b rv=%b want 0 0", rsp_err, rsp_valid); n_bad++; end n_cmp++;
        tick();
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_fun3  = 3'b000;
        #3;
        test_reset();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        test_aligned();
`ifdef DMEM_MISALIGN_SPLIT_EN
        test_split_store();
        test_split_load_sign();
        test_wrap();
        test_reset_mid_split();
`else
        test_misalign_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_seq.md
# dmem_access_seq

Load/store access sequencer between the core's load-store stage and the byte-enabled data memory. Aligned accesses pass straight through in zero cycles. Misaligned halfword/word accesses, which the memory's byte-lane logic cannot serve, are decomposed into per-byte accesses over several cycles while the core is stalled. Loads are reassembled and sign/zero-extended here.

## Interface
- `WIDTH`, 32: data/address width; only 32 supported.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: core load/store request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in WIDTH: byte address.
- `req_wdata` in WIDTH: store data, right-aligned.
- `req_fun3` in 3: RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_ready` out 1: request accepted this cycle.
- `stall` out 1: core must hold its load-store stage.
- `rsp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `rsp_rdata` out WIDTH: extended load data; 0 for stores.
- `rsp_err` out 1: misaligned fault; only when split is compiled out.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out WIDTH: memory address.
- `mem_wdata` out WIDTH: memory write data.
- `mem_fun3` out 3: memory access size/sign.
- `mem_rdata` in WIDTH: memory read data, combinational from `mem_addr`.

## Operation
- Misaligned definition:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - B/BU never misaligned.
  - Reserved funct3 (011, 110, 111) is never misaligned and passes through unchanged.
- FSM states: IDLE, SPLIT, DONE.
- IDLE:
  - `req_ready`=1.
  - Aligned request: `mem_*` driven combinationally from `req_*`, with `mem_write`=`req_valid&req_write`.
  - Aligned request response: `rsp_valid`=`req_valid`, same cycle. `rsp_rdata`=`mem_rdata` for loads (memory does extension), 0 for stores.
  - Misaligned request, `req_valid`=1:
    - No memory access this cycle; `mem_write`=0.
    - `stall`=1.
    - Capture addr, wdata, fun3, write into registers.
    - Set byte count N = 2 (H/HU) or 4 (W); clear byte counter k.
    - Go to SPLIT.
- SPLIT, one byte per cycle, k = 0..N-1:
  - `mem_addr` = captured addr + k, modulo 2^32 (wrap at 0xFFFFFFFF is legal).
  - Store: `mem_fun3`=000 (SB), `mem_write`=1, `mem_wdata`={24'b0, wdata byte k}.
  - Load: `mem_fun3`=100 (LBU), `mem_write`=0; `mem_rdata[7:0]` latched into assembly byte k.
  - `stall`=1, `req_ready`=0.
  - After k=N-1, go to DONE.
- DONE:
  - `rsp_valid`=1, `stall`=0, `req_ready`=0, `mem_write`=0.
  - `rsp_rdata`: H → sign-extend from bit 15; HU → zero-extend; W → assembled word; store → 0.
  - Next state is IDLE. A new request is not accepted until IDLE.
- Outputs outside active use:
  - `mem_addr`/`mem_wdata`/`mem_fun3` pass `req_*` through in IDLE and DONE.
  - Assembly register holds its last value.

## Timing
- Aligned: 0-cycle latency; accept and response in the same cycle.
- Misaligned: accept at cycle 0; byte accesses in cycles 1..N; `rsp_valid` at cycle N+1 (3 cycles for H, 5 for W).
- Back-to-back: a request presented in the DONE cycle is ignored and must be re-presented. The core guarantees this because `stall` drops with `rsp_valid`.
- Reset values:
  - state = IDLE, k = 0, assembly = 0.
  - `rsp_valid`=0, `rsp_err`=0.
  - `mem_write`=0 unless an aligned store is presented combinationally.
- Reset asserted mid-SPLIT:
  - Immediate return to IDLE; no further `mem_write`.
  - No `rsp_valid` for the aborted request.
  - Bytes already stored remain in memory (partial store is accepted behaviour).

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` defined: behaviour as above; `rsp_err` tied 0.
- Undefined: SPLIT and DONE are removed. A misaligned request in IDLE gives:
  - no memory access, `mem_write`=0;
  - `rsp_valid`=1 and `rsp_err`=1 in the same cycle;
  - `rsp_rdata`=0 and `stall`=0.

  Aligned behaviour is identical in both builds.

## Test plan
- Aligned LW at 0x100 holding 0x12345678 → same-cycle `rsp_valid`, `rsp_rdata`=0x12345678, `stall`=0.
- SW 0xAABBCCDD at 0x101 → 4 SB cycles writing DD@0x101, CC@0x102, BB@0x103, AA@0x104. `rsp_valid` is asserted on cycle 5. A following LW 0x101 returns 0xAABBCCDD on cycle 5.
- Bytes 0x7F@0x103 and 0x80@0x104:
  - LH 0x103 → 0xFFFF807F after 3 cycles.
  - LHU 0x103 → 0x0000807F.
- SW 0x11223344 at 0xFFFFFFFF → addresses 0xFFFFFFFF, 0x0, 0x1, 0x2 receive 44, 33, 22, 11.
- Reset asserted during the k=1 cycle of a misaligned SW at 0x201 → FSM returns to IDLE, no `rsp_valid`, only byte 0x201 modified.
- Macro undefined, LW 0x102 → same-cycle `rsp_valid`=1, `rsp_err`=1, `mem_write`=0, `rsp_rdata`=0.
